// File: rtl/ps2_host_tx_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-to-device transmitter.
//   - ps2_state_e      : transmitter FSM states
//   - CMD_*            : common keyboard command bytes
//   - *_EDGE           : falling-edge numbers of the host-to-device frame
//   - odd_parity()     : parity bit sent after the data byte
//   - us_to_cycles()   : microseconds -> clock cycles, 64-bit intermediate
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        FAIL
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [3:0] LAST_DATA_EDGE = 4'd8;
    localparam logic [3:0] PARITY_EDGE    = 4'd9;
    localparam logic [3:0] STOP_EDGE      = 4'd10;
    localparam logic [3:0] ACK_EDGE       = 4'd11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // The product overflows 32 bits for long timeouts at MHz clocks.
    function automatic int us_to_cycles(input int clk_hz, input int us);
        longint prod;
        prod = longint'(clk_hz) * longint'(us);
        return int'(prod / longint'(1000000));
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte request interface of the PS/2 host transmitter.
//   tx_data  [7:0] command byte          (master -> slave)
//   tx_valid       request               (master -> slave)
//   tx_ready       idle, can accept      (slave -> master)
//   tx_done        1-cycle pulse on ACK  (slave -> master)
//   tx_error       1-cycle pulse on NACK/timeout (slave -> master)
// Handshake: a byte transfers in the cycle where tx_valid & tx_ready are both
// high at the rising clock edge; tx_data must be stable in that cycle. While
// tx_ready is low tx_valid is ignored and nothing is queued. Exactly one of
// tx_done / tx_error pulses per accepted byte, and tx_ready is high again in
// the following cycle.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pin.
//   clk_sys  in  system clock
//   reset_n  in  synchronous active-low reset
//   raw_i    in  asynchronous pin level
//   level_o  out filtered level (idle high after reset)
//   fall_o   out one-cycle strobe on an accepted 1->0 change of level_o
// A 2-flop synchroniser is followed by a filter that only accepts a new level
// after FILTER_LEN consecutive samples disagree with the current one.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q, level_q, fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            fall_q  <= 1'b0;
            if (sync2_q == level_q) begin
                // Any agreeing sample restarts the run of disagreeing ones.
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device over the
// open-drain clock/data pair, holding the receive port disabled meanwhile.
//   clk_sys, reset_n        clock, synchronous active-low reset
//   ps2clk_in, ps2data_in   raw pin levels
//   ps2clk_oe, ps2data_oe   1 = pull pin low, 0 = release
//   rcv_enable              0 while a transaction is in progress
//   tx                      byte request interface (slave side)
//   dbg_state               current FSM state
// Optional build macro PS2_HOST_TX_RETRY_EN: on NACK or timeout the latched
// byte is resent from INHIBIT up to two more times before tx_error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 8000000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_US  = 15000,
    parameter int FILTER_LEN  = 4
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         ps2clk_in,
    input  logic         ps2data_in,
    output logic         ps2clk_oe,
    output logic         ps2data_oe,
    output logic         rcv_enable,
    ps2_host_tx_if.slave tx,
    output ps2_state_e   dbg_state
);
    localparam int INH_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int TO_CYC  = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int INH_W   = $clog2(INH_CYC);
    localparam int TO_W    = $clog2(TO_CYC);

    logic clk_level, clk_fall, data_level, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw_i   (ps2clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    // Data is only sampled at clock edges, so it needs no glitch filter;
    // its falling-edge strobe is not used.
    ps2_line_filter #(.FILTER_LEN(1)) u_data_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw_i   (ps2data_in),
        .level_o (data_level),
        .fall_o  (data_fall_unused)
    );

    ps2_state_e       state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             data_oe_q, data_oe_d;
    logic             inh_last, timeout, fail_now;
    logic [3:0]       edge_n;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            data_oe_q <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            data_oe_q <= data_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign inh_last = (state_q == INHIBIT) && (inh_cnt_q == INH_W'(INH_CYC - 1));
    assign timeout  = (to_cnt_q == TO_W'(TO_CYC - 1));
    // Number of the falling edge being reported by clk_fall this cycle.
    assign edge_n   = bit_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = '0;
        to_cnt_d  = '0;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        data_oe_d = data_oe_q;
        fail_now  = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        if (state_q inside {REQ, SHIFT, ACK, WAIT_IDLE}) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                data_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
                retry_d   = '0;
`endif
                if (tx.tx_valid) begin
                    data_d  = tx.tx_data;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                bit_cnt_d = '0;
                if (inh_last) begin
                    data_oe_d = 1'b1;  // start bit
                    state_d   = REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            REQ: begin
                if (timeout) fail_now = 1'b1;
                else         state_d  = SHIFT;
            end
            SHIFT: begin
                // Timeout is checked first so it wins over a coincident edge.
                if (timeout) begin
                    fail_now = 1'b1;
                end else if (clk_fall) begin
                    bit_cnt_d = edge_n;
                    if (edge_n <= LAST_DATA_EDGE) begin
                        data_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (edge_n == PARITY_EDGE) begin
                        data_oe_d = ~odd_parity(data_q);
                    end else if (edge_n == STOP_EDGE) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end
            ACK: begin
                if (timeout) begin
                    fail_now = 1'b1;
                end else if (clk_fall) begin
                    bit_cnt_d = edge_n;
                    if (edge_n == ACK_EDGE && !data_level) state_d  = WAIT_IDLE;
                    else                                    fail_now = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (timeout)                      fail_now = 1'b1;
                else if (clk_level && data_level) state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fail_now) begin
            data_oe_d = 1'b0;
            to_cnt_d  = '0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d = retry_q + 2'd1;
                state_d = INHIBIT;
            end else begin
                state_d = FAIL;
            end
`else
            state_d = FAIL;
`endif
        end
    end

    assign ps2clk_oe   = (state_q == INHIBIT);
    // The start bit is already driven during the last inhibit cycle.
    assign ps2data_oe  = data_oe_q | inh_last;
    assign tx.tx_ready = (state_q == IDLE);
    assign tx.tx_done  = (state_q == DONE);
    assign tx.tx_error = (state_q == FAIL);
    assign rcv_enable  = (state_q == IDLE) || (state_q == DONE) || (state_q == FAIL);
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int TB_TIMEOUT_US = 1200;
    localparam int T_CYC         = TB_TIMEOUT_US * 8;  // 8 MHz clock
    localparam int INH_EXP       = 960;
    localparam int HALF          = 320;                // 12.5 kHz device clock
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS      = 3;
`else
    localparam int ATTEMPTS      = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ---------------- DUT and open-drain pin model ----------------
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       glitch   = 1'b0;
    logic       ps2clk_in, ps2data_in;
    logic       ps2clk_oe, ps2data_oe, rcv_enable;
    ps2_state_e dbg_state;

    assign ps2clk_in  = (~ps2clk_oe & dev_clk) ^ glitch;
    assign ps2data_in = ~ps2data_oe & dev_data;

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(.TIMEOUT_US(TB_TIMEOUT_US)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe),
        .rcv_enable (rcv_enable),
        .tx         (tx_if),
        .dbg_state  (dbg_state)
    );

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic score(input string tag, input logic [10:0] got);
        logic [10:0] exp;
        check_eq({tag, "_sb_has_exp"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check_eq({tag, "_frame"}, 32'(got), 32'(exp));
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0, run_len = 0, last_inh_len = 0, req_cyc = 0, inh_seen = 0;
    int   done_cnt = 0, err_cnt = 0, err_cyc = 0, rcv_leak = 0, ready_late = 0;
    logic prev_term = 1'b0;

    always @(negedge clk_sys) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            run_len   <= 0;
            prev_term <= 1'b0;
        end else begin
            if (ps2clk_oe) begin
                run_len <= run_len + 1;
            end else if (run_len > 0) begin
                last_inh_len <= run_len;
                req_cyc      <= cyc;
                inh_seen     <= inh_seen + 1;
                run_len      <= 0;
            end
            if (tx_if.tx_done) done_cnt <= done_cnt + 1;
            if (tx_if.tx_error) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            if (!tx_if.tx_ready && !tx_if.tx_done && !tx_if.tx_error && rcv_enable)
                rcv_leak <= rcv_leak + 1;
            if (prev_term && !tx_if.tx_ready) ready_late <= ready_late + 1;
            prev_term <= tx_if.tx_done | tx_if.tx_error;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input int copies);
        int n;
        n = 0;
        while (!tx_if.tx_ready && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("ready_before_send", 32'(tx_if.tx_ready), 32'd1);
        for (int i = 0; i < copies; i++) exp_q.push_back({1'b1, ~^b, b, 1'b0});
        tx_if.tx_data  = b;
        tx_if.tx_valid = 1'b1;
        @(negedge clk_sys);
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic half_wait(input bit glitchy);
        repeat (HALF / 2) @(negedge clk_sys);
        if (glitchy) glitch = 1'b1;
        @(negedge clk_sys);
        glitch = 1'b0;
        repeat (HALF / 2 - 1) @(negedge clk_sys);
    endtask

    // Device side of one frame: waits for request-to-send, clocks 11 pulses,
    // samples start/data/parity/stop on rising edges and answers ACK or NACK.
    task automatic dev_frame(input int abort_at, input bit nack, input bit glitchy,
                             output logic [10:0] frame);
        int n;
        frame = '0;
        n = 0;
        while (!(ps2clk_in && !ps2data_in) && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("dev_rts_seen", 32'(n < 3000), 32'd1);
        if (n >= 3000) return;
        repeat (100) @(negedge clk_sys);
        frame[0] = ps2data_in;
        for (int p = 1; p <= 11; p++) begin
            dev_clk = 1'b0;
            if (p == abort_at) begin
                repeat (20) @(negedge clk_sys);
                dev_clk = 1'b1;
                return;
            end
            half_wait(glitchy);
            dev_clk = 1'b1;
            if (p <= 10) frame[p] = ps2data_in;
            if (p == 11) dev_data = 1'b1;
            if (p == 10) begin
                repeat (HALF / 4) @(negedge clk_sys);
                dev_data = nack;
                repeat (HALF - HALF / 4) @(negedge clk_sys);
            end else begin
                half_wait(glitchy);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [10:0] frame_v;
    int d0, e0, l0, i0, r0, n;

    initial begin
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_eq("rst_clk_oe",     32'(ps2clk_oe),      32'd0);
        check_eq("rst_data_oe",    32'(ps2data_oe),     32'd0);
        check_eq("rst_ready",      32'(tx_if.tx_ready), 32'd1);
        check_eq("rst_done",       32'(tx_if.tx_done),  32'd0);
        check_eq("rst_error",      32'(tx_if.tx_error), 32'd0);
        check_eq("rst_rcv_enable", 32'(rcv_enable),     32'd1);
        check_eq("rst_state",      32'(dbg_state == IDLE), 32'd1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        // 1: 0xED, ACKed
        d0 = done_cnt; e0 = err_cnt; l0 = rcv_leak;
        send_byte(CMD_SET_LEDS, 1);
        dev_frame(0, 1'b0, 1'b0, frame_v);
        score("t1", frame_v);
        repeat (20) @(negedge clk_sys);
        check_eq("t1_inhibit_len", 32'(last_inh_len),  32'(INH_EXP));
        check_eq("t1_done",        32'(done_cnt - d0), 32'd1);
        check_eq("t1_error",       32'(err_cnt - e0),  32'd0);
        check_eq("t1_rcv_low",     32'(rcv_leak - l0), 32'd0);

        // 2: 0xF4, ready right after done
        d0 = done_cnt; r0 = ready_late;
        send_byte(CMD_ENABLE, 1);
        dev_frame(0, 1'b0, 1'b0, frame_v);
        score("t2", frame_v);
        repeat (20) @(negedge clk_sys);
        check_eq("t2_done",       32'(done_cnt - d0),   32'd1);
        check_eq("t2_ready_next", 32'(ready_late - r0), 32'd0);

        // 3: device never clocks -> timeout
        d0 = done_cnt; e0 = err_cnt; i0 = inh_seen;
        send_byte(CMD_RESET, 0);
        n = 0;
        while (err_cnt == e0 && n < ATTEMPTS * (T_CYC + INH_EXP) + 2000) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (2) @(negedge clk_sys);
        check_eq("t3_error",      32'(err_cnt - e0),     32'd1);
        check_eq("t3_err_time",   32'(err_cyc - req_cyc), 32'(T_CYC));
        check_eq("t3_attempts",   32'(inh_seen - i0),    32'(ATTEMPTS));
        check_eq("t3_no_done",    32'(done_cnt - d0),    32'd0);
        check_eq("t3_clk_oe",     32'(ps2clk_oe),        32'd0);
        check_eq("t3_data_oe",    32'(ps2data_oe),       32'd0);

        // 4: NACK at edge 11
        d0 = done_cnt; e0 = err_cnt;
        send_byte(CMD_ENABLE, ATTEMPTS);
        for (int a = 0; a < ATTEMPTS; a++) begin
            dev_frame(0, 1'b1, 1'b0, frame_v);
            score("t4", frame_v);
        end
        repeat (20) @(negedge clk_sys);
        check_eq("t4_error",   32'(err_cnt - e0),  32'd1);
        check_eq("t4_no_done", 32'(done_cnt - d0), 32'd0);

        // 5: reset in SHIFT after edge 5, then a clean 0xF4
        send_byte(CMD_SET_LEDS, 0);
        dev_frame(5, 1'b0, 1'b0, frame_v);
        check_eq("t5_in_shift",  32'(dbg_state == SHIFT), 32'd1);
        check_eq("t5_data_pre",  32'(ps2data_oe),         32'd1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        check_eq("t5_clk_oe",     32'(ps2clk_oe),      32'd0);
        check_eq("t5_data_oe",    32'(ps2data_oe),     32'd0);
        check_eq("t5_ready",      32'(tx_if.tx_ready), 32'd1);
        check_eq("t5_rcv_enable", 32'(rcv_enable),     32'd1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        d0 = done_cnt;
        send_byte(CMD_ENABLE, 1);
        dev_frame(0, 1'b0, 1'b0, frame_v);
        score("t5", frame_v);
        repeat (20) @(negedge clk_sys);
        check_eq("t5_done", 32'(done_cnt - d0), 32'd1);

        // 6: busy tx_valid with 0x55 and glitches on the clock pin
        d0 = done_cnt;
        send_byte(CMD_SET_LEDS, 1);
        fork
            dev_frame(0, 1'b0, 1'b1, frame_v);
            begin
                repeat (300) @(negedge clk_sys);
                tx_if.tx_data  = 8'h55;
                tx_if.tx_valid = 1'b1;
                @(negedge clk_sys);
                tx_if.tx_valid = 1'b0;
                repeat (3000) @(negedge clk_sys);
                tx_if.tx_valid = 1'b1;
                @(negedge clk_sys);
                tx_if.tx_valid = 1'b0;
            end
        join
        score("t6", frame_v);
        i0 = inh_seen;
        repeat (1500) @(negedge clk_sys);
        check_eq("t6_done",       32'(done_cnt - d0), 32'd1);
        check_eq("t6_no_resend",  32'(inh_seen - i0), 32'd0);

        check_eq("sb_drained",      32'(exp_q.size()), 32'd0);
        check_eq("ready_after_end", 32'(ready_late),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end
endmodule
